// File: rtl/param_shift_reg.sv
// Multi-mode shift register: parallel load, then shift or rotate by a programmable
// amount at one bit per clock, with a start/busy/done handshake.
module param_shift_reg #(
  parameter int WIDTH   = 8,  // must be at least 2
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               sin,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout,
  output logic               sout
);

  // Handshake: start is sampled only in IDLE; busy covers SHIFT and DONE, and
  // done is a single-cycle pulse in DONE with dout already final.
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] M_NOP  = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_SHL  = 3'b011;
  localparam logic [2:0] M_SRA  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ROL  = 3'b110;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

  state_t             state, state_nx;
  logic [SHAMT_W-1:0] cnt, cnt_nx;
  logic [2:0]         mode_q, mode_nx;
  logic [WIDTH-1:0]   dout_nx, step_val;
  logic               sout_nx, step_out;
  logic               is_shift_mode;

  assign is_shift_mode = (mode >= M_SHR) && (mode <= M_ROL);

  // One bit-position step of the latched operation on the current contents.
  always_comb begin
    step_val = dout;
    step_out = sout;
    case (mode_q)
      M_SHR: begin step_val = {sin, dout[WIDTH-1:1]};        step_out = dout[0];       end
      M_SHL: begin step_val = {dout[WIDTH-2:0], sin};        step_out = dout[WIDTH-1]; end
      M_SRA: begin step_val = {dout[WIDTH-1], dout[WIDTH-1:1]}; step_out = dout[0];    end
      M_ROR: begin step_val = {dout[0], dout[WIDTH-1:1]};    step_out = dout[0];       end
      M_ROL: begin step_val = {dout[WIDTH-2:0], dout[WIDTH-1]}; step_out = dout[WIDTH-1]; end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mode_nx  = mode_q;
    dout_nx  = dout;
    sout_nx  = sout;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = DONE;
          if (mode == M_LOAD) begin
            dout_nx = load_val;
          end else if (is_shift_mode && shamt != CNT_ZERO) begin
            mode_nx  = mode;
            cnt_nx   = shamt;
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        dout_nx = step_val;
        sout_nx = step_out;
        cnt_nx  = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= M_NOP;
      dout   <= '0;
      sout   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      mode_q <= mode_nx;
      dout   <= dout_nx;
      sout   <= sout_nx;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_param_shift_reg.sv
// Directed and randomized checks of param_shift_reg against an arithmetic
// reference model of the shift/rotate rules and the handshake timing.
module tb_param_shift_reg;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [3:0] shamt = 4'd0;
  logic [7:0] load_val = 8'h00;
  logic       sin = 1'b0;
  logic       busy, done, sout;
  logic [7:0] dout;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] m;
  logic       sout_m;

  param_shift_reg #(.WIDTH(8), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .shamt(shamt),
    .load_val(load_val), .sin(sin), .busy(busy), .done(done), .dout(dout), .sout(sout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference step: plain integer arithmetic on the value, returns {out_bit, value}.
  function automatic logic [8:0] ref_step(input logic [7:0] v, input logic [2:0] md, input logic s);
    int x, nv, so;
    x = int'(v);
    nv = x;
    so = 0;
    case (md)
      3'd2: begin nv = x / 2 + (s ? 128 : 0);       so = x % 2;   end
      3'd3: begin nv = (x * 2 + int'(s)) % 256;     so = x / 128; end
      3'd4: begin nv = x / 2 + (x >= 128 ? 128 : 0); so = x % 2;  end
      3'd5: begin nv = x / 2 + (x % 2) * 128;       so = x % 2;   end
      3'd6: begin nv = (x * 2) % 256 + x / 128;     so = x / 128; end
      default: ;
    endcase
    return {so[0], nv[7:0]};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'(m));
    check({tag, "_sout"}, 32'(sout), 32'(sout_m));
  endtask

  // Issue one request from IDLE and follow it to completion, checking every cycle.
  task automatic run_op(input logic [2:0] md, input logic [3:0] n, input logic [7:0] lv,
                        input logic [15:0] sin_bits, input bit rnd);
    int steps;
    logic [8:0] r;
    mode = md; shamt = n; load_val = lv; start = 1'b1;
    sin = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    mode = 3'($urandom); shamt = 4'($urandom); load_val = 8'($urandom);
    steps = (md >= 3'd2 && md <= 3'd6) ? int'(n) : 0;
    if (md == 3'd1) m = lv;
    for (int i = 0; i < steps; i++) begin
      check("shift_busy", 32'(busy), 32'd1);
      check("shift_done", 32'(done), 32'd0);
      sin = rnd ? 1'($urandom_range(0, 1)) : sin_bits[i];
      @(posedge clk); #1;
      r = ref_step(m, md, sin);
      {sout_m, m} = r;
    end
    check("fin_done", 32'(done), 32'd1);
    check("fin_busy", 32'(busy), 32'd1);
    check("fin_dout", 32'(dout), 32'(m));
    check("fin_sout", 32'(sout), 32'(sout_m));
    @(posedge clk); #1;
    check_idle("after");
  endtask

  initial begin
    logic [8:0] r;
    m = 8'h00; sout_m = 1'b0;

    // Reset held with random inputs and a running clock.
    #1 rst_n = 1'b0;
    #1 check("rst_async_dout", 32'(dout), 32'd0);
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); mode = 3'($urandom); shamt = 4'($urandom);
      load_val = 8'($urandom); sin = 1'($urandom);
      @(posedge clk); #1;
      check_idle("rst_hold");
    end
    start = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_idle("rst_release");
    end

    // LOAD 0xA5, SHR 1 with sin=1.
    run_op(3'd1, 4'd0, 8'hA5, 16'h0, 1'b0);
    check("load_a5", 32'(dout), 32'hA5);
    run_op(3'd2, 4'd1, 8'h00, 16'h1, 1'b0);
    check("shr1_dout", 32'(dout), 32'hD2);
    check("shr1_sout", 32'(sout), 32'd1);

    // LOAD 0x90, SRA 3, then SHL 2 with sin 1,0.
    run_op(3'd1, 4'd0, 8'h90, 16'h0, 1'b0);
    run_op(3'd4, 4'd3, 8'h00, 16'h0, 1'b1);
    check("sra3_dout", 32'(dout), 32'hF2);
    check("sra3_sout", 32'(sout), 32'd0);
    run_op(3'd3, 4'd2, 8'h00, 16'b01, 1'b0);
    check("shl2_dout", 32'(dout), 32'hCA);
    check("shl2_sout", 32'(sout), 32'd1);

    // Rotates past and at the word width.
    run_op(3'd1, 4'd0, 8'h81, 16'h0, 1'b0);
    run_op(3'd6, 4'd9, 8'h00, 16'h0, 1'b1);
    check("rol9_dout", 32'(dout), 32'h03);
    check("rol9_sout", 32'(sout), 32'd1);
    run_op(3'd1, 4'd0, 8'h81, 16'h0, 1'b0);
    run_op(3'd5, 4'd8, 8'h00, 16'h0, 1'b1);
    check("ror8_dout", 32'(dout), 32'h81);

    // shamt=0 and reserved mode leave dout and sout untouched.
    run_op(3'd2, 4'd0, 8'h00, 16'h0, 1'b1);
    check("sh0_dout", 32'(dout), 32'h81);
    run_op(3'd7, 4'd5, 8'h3C, 16'h0, 1'b1);
    check("m7_dout", 32'(dout), 32'h81);

    // start held high across a SHR 4: next accept at E6.
    mode = 3'd2; shamt = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("hold_busy", 32'(busy), 32'd1);
      sin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      r = ref_step(m, 3'd2, sin);
      {sout_m, m} = r;
    end
    check("hold_done", 32'(done), 32'd1);
    check("hold_dout", 32'(dout), 32'(m));
    @(posedge clk); #1;
    check_idle("hold_e5");
    @(posedge clk); #1;
    check("hold_e6_busy", 32'(busy), 32'd1);
    check("hold_e6_done", 32'(done), 32'd0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      r = ref_step(m, 3'd2, sin);
      {sout_m, m} = r;
    end
    check("hold2_done", 32'(done), 32'd1);
    check("hold2_dout", 32'(dout), 32'(m));
    @(posedge clk); #1;
    check_idle("hold2_after");

    // Reset in the middle of SHL 5 on 0xFF.
    run_op(3'd1, 4'd0, 8'hFF, 16'h0, 1'b0);
    mode = 3'd3; shamt = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sin = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    m = 8'h00; sout_m = 1'b0;
    #1 check_idle("midrst");
    repeat (3) begin
      @(posedge clk); #1;
      check_idle("midrst_hold");
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(3'd1, 4'd0, 8'h5A, 16'h0, 1'b0);
    run_op(3'd3, 4'd5, 8'h00, 16'h0, 1'b1);

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom), 4'($urandom), 8'($urandom), 16'h0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
